// File: rtl/oser10_pkg.sv
// Shared types and constants for the OSER10 word feeder.
package oser10_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DIV    = 5;

  localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 10'h2AA;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/oser10_feeder_pclk_div5.sv
// Divide-by-5 PCLK generator with a word-boundary marker (cnt == 4).
module pclk_div5
  import oser10_pkg::*;
(
  input  logic fclk_w,
  input  logic rst,
  output logic pclk_o,
  output logic boundary
);

  logic [2:0] cnt;
  logic       clk_a;
  logic       clk_b;

  // Free-running modulo-5 phase counter.
  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == 3'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 3'd1;
    end
  end

  assign clk_a = cnt[1];

  // Half-cycle delayed copy of clk_a; OR-ing both stretches the high phase to 2.5 cycles.
  always_ff @(negedge fclk_w) begin
    if (!rst) begin
      clk_b <= 1'b0;
    end else begin
      clk_b <= clk_a;
    end
  end

  assign pclk_o   = clk_a | clk_b;
  assign boundary = (cnt == 3'(DIV - 1));

endmodule

// File: rtl/oser10_feeder.sv
// OSER10 word scheduler: PCLK generation, start-up reset hold, input FIFO
// and one word per PCLK period onto the serializer parallel inputs.
module oser10_feeder
  import oser10_pkg::*;
#(
  parameter int unsigned          DEPTH          = 4,
  parameter logic [WORD_W-1:0]    IDLE_WORD      = IDLE_WORD_DEFAULT,
  parameter int unsigned          STARTUP_CYCLES = 20
) (
  input  logic              fclk_w,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pclk_o,
  output logic [WORD_W-1:0] oser_d,
  output logic              oser_reset,
  output logic              word_strobe,
  output logic              underflow,
  output logic [1:0]        state_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SU_W  = $clog2(STARTUP_CYCLES);

  logic              boundary;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic              fifo_ne;
  logic [SU_W-1:0]   su_cnt;
  logic              su_done;

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] d_next;
  logic              ws_next;
  logic              uf_next;

  pclk_div5 u_div (
    .fclk_w   (fclk_w),
    .rst      (rst),
    .pclk_o   (pclk_o),
    .boundary (boundary)
  );

  assign in_ready = rst & (count != (PTR_W + 1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign fifo_ne  = (count != '0);

  // FIFO storage; no reset needed, validity is tracked by count.
  always_ff @(posedge fclk_w) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Start-up window counter: counts fclk edges since rst rose, saturating.
  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      su_cnt <= '0;
    end else if (state_q == HOLD && !su_done) begin
      su_cnt <= su_cnt + SU_W'(1);
    end
  end

  assign su_done = (su_cnt == SU_W'(STARTUP_CYCLES - 1));

  // Next-state, pop decision and next output word, evaluated per boundary.
  always_comb begin
    state_d = state_q;
    d_next  = oser_d;
    ws_next = 1'b0;
    uf_next = 1'b0;
    pop     = 1'b0;
    case (state_q)
      HOLD: begin
        if (boundary && su_done) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (boundary && fifo_ne) begin
          pop     = 1'b1;
          d_next  = mem[rptr];
          ws_next = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (boundary) begin
          if (fifo_ne) begin
            pop     = 1'b1;
            d_next  = mem[rptr];
            ws_next = 1'b1;
          end else begin
            d_next  = IDLE_WORD;
            uf_next = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = HOLD;
        d_next  = IDLE_WORD;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      state_q     <= HOLD;
      oser_d      <= IDLE_WORD;
      word_strobe <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      oser_d      <= d_next;
      word_strobe <= ws_next;
      underflow   <= uf_next;
    end
  end

  assign oser_reset = (state_q == HOLD);
  assign state_o    = state_q;

endmodule

// File: tb/tb_oser10_feeder.sv
// Self-checking bench for oser10_feeder.
module tb_oser10_feeder;

  logic       fclk_w = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       pclk_o;
  logic [9:0] oser_d;
  logic       oser_reset;
  logic       word_strobe;
  logic       underflow;
  logic [1:0] state_o;

  always #5 fclk_w = ~fclk_w;

  oser10_feeder #(
    .DEPTH          (4),
    .IDLE_WORD      (10'h2AA),
    .STARTUP_CYCLES (20)
  ) dut (
    .fclk_w      (fclk_w),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pclk_o      (pclk_o),
    .oser_d      (oser_d),
    .oser_reset  (oser_reset),
    .word_strobe (word_strobe),
    .underflow   (underflow),
    .state_o     (state_o)
  );

  typedef struct {
    bit         rst;
    bit         vld;
    logic [9:0] din;
    logic [1:0] st;
    logic [9:0] d;
    bit         ws;
    bit         uf;
    bit         rdy;
    bit         orst;
    bit         pclk;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic step();
    @(posedge fclk_w);
    #1;
    e++;
  endtask

  function automatic void add(bit r, bit v, logic [9:0] di, logic [1:0] s, logic [9:0] d,
                              bit ws, bit uf, bit rdy, bit orst, bit pc);
    vec_t t;
    t.rst = r; t.vld = v; t.din = di; t.st = s; t.d = d;
    t.ws = ws; t.uf = uf; t.rdy = rdy; t.orst = orst; t.pclk = pc;
    tbl.push_back(t);
  endfunction

  // pclk sampled just after the rising edge: high for phases 2,3,4
  function automatic bit pc_pos(int k);
    return (k % 5) >= 2;
  endfunction

  // pclk sampled just after the falling edge: high for phases 2,3
  function automatic bit pc_neg(int k);
    return ((k % 5) == 2) || ((k % 5) == 3);
  endfunction

  initial begin
    logic [9:0] pre [3];
    int  accepted, strobes, ufs, last_sb;
    bit  seen_full, acc;

    // Entry k = fclk edge number since rst rose (entry 0 is still in reset).
    add(0, 0, 10'h000, 2'd0, 10'h2AA, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 19; k++) add(1, 0, 10'h000, 2'd0, 10'h2AA, 0, 0, 1, 1, pc_pos(k));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(20));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(21));
    add(1, 1, 10'h3C1, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(22));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(23));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(24));
    add(1, 0, 10'h000, 2'd2, 10'h3C1, 1, 0, 1, 0, pc_pos(25));
    for (int k = 26; k <= 29; k++) add(1, 0, 10'h000, 2'd2, 10'h3C1, 0, 0, 1, 0, pc_pos(k));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 1, 1, 0, pc_pos(30));
    add(1, 0, 10'h000, 2'd1, 10'h2AA, 0, 0, 1, 0, pc_pos(31));

    // Settle reset (negedge flop is unknown before the first reset edge).
    rst = 1'b0;
    step();
    step();

    // Reset, start-up window, single word, underflow.
    for (int i = 0; i < tbl.size(); i++) begin
      rst      = tbl[i].rst;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      step();
      chk($sformatf("v%0d.state", i),    state_o,     tbl[i].st);
      chk($sformatf("v%0d.oser_d", i),   oser_d,      tbl[i].d);
      chk($sformatf("v%0d.strobe", i),   word_strobe, tbl[i].ws);
      chk($sformatf("v%0d.underflow", i), underflow,  tbl[i].uf);
      chk($sformatf("v%0d.in_ready", i), in_ready,    tbl[i].rdy);
      chk($sformatf("v%0d.oser_reset", i), oser_reset, tbl[i].orst);
      chk($sformatf("v%0d.pclk", i),     pclk_o,      tbl[i].pclk);
    end
    in_valid = 1'b0;
    e = 31;

    // Burst of 8 words with in_valid held, DEPTH 4.
    accepted = 0; strobes = 0; ufs = 0; last_sb = -1; seen_full = 1'b0;
    in_valid = 1'b1;
    in_data  = 10'h001;
    for (int c = 0; c < 50; c++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) accepted++;
      if (word_strobe) begin
        strobes++;
        chk("burst.word", oser_d, strobes);
        if (last_sb >= 0) chk("burst.gap", e - last_sb, 5);
        last_sb = e;
      end
      if (underflow) begin
        ufs++;
        chk("burst.uf_after_last", strobes, 8);
        chk("burst.uf_gap", e - last_sb, 5);
        chk("burst.uf_oser_d", oser_d, 10'h2AA);
      end
      if (!in_ready && !seen_full) begin
        seen_full = 1'b1;
        chk("burst.full_level", accepted - strobes, 4);
      end
      in_valid = (accepted < 8);
      in_data  = 10'(accepted + 1);
    end
    in_valid = 1'b0;
    chk("burst.accepted", accepted, 8);
    chk("burst.strobes", strobes, 8);
    chk("burst.underflows", ufs, 1);
    chk("burst.saw_full", seen_full, 1);
    chk("burst.end_state", state_o, 2'd1);

    // Prefill 3 words during HOLD.
    pre[0] = 10'h155; pre[1] = 10'h0F0; pre[2] = 10'h30F;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    e = 0;
    in_valid = 1'b1;
    in_data  = pre[0];
    repeat (40) begin
      step();
      chk("pre.state", state_o, (e < 20) ? 2'd0 : (e < 25) ? 2'd1 : (e < 40) ? 2'd2 : 2'd1);
      chk("pre.strobe", word_strobe, (e == 25) || (e == 30) || (e == 35));
      chk("pre.underflow", underflow, e == 40);
      chk("pre.oser_d", oser_d, (e < 25) ? 10'h2AA : (e < 30) ? pre[0] :
                                (e < 35) ? pre[1] : (e < 40) ? pre[2] : 10'h2AA);
      chk("pre.oser_reset", oser_reset, e < 20);
      in_valid = (e < 3);
      in_data  = (e < 3) ? pre[e] : 10'h000;
    end
    in_valid = 1'b0;

    // Reset mid-stream with 2 words still queued.
    in_valid = 1'b1;
    in_data  = 10'h111; step();
    in_data  = 10'h222; step();
    in_data  = 10'h333; step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid.first_word", oser_d, 10'h111);
    chk("mid.streaming", state_o, 2'd2);
    step();
    rst = 1'b0;
    step();
    chk("mid.in_ready", in_ready, 1'b0);
    chk("mid.oser_d", oser_d, 10'h2AA);
    chk("mid.oser_reset", oser_reset, 1'b1);
    chk("mid.state", state_o, 2'd0);
    chk("mid.strobe", word_strobe, 1'b0);
    chk("mid.pclk", pclk_o, 1'b0);
    step();
    chk("mid.pclk_held", pclk_o, 1'b0);

    // After release: flushed words never appear; push on a boundary waits a full period.
    rst = 1'b1;
    e = 0;
    repeat (40) begin
      step();
      chk("post.strobe", word_strobe, e == 30);
      chk("post.underflow", underflow, e == 35);
      chk("post.oser_d", oser_d, (e >= 30 && e < 35) ? 10'h0AB : 10'h2AA);
      chk("post.state", state_o, (e < 20) ? 2'd0 : (e < 30) ? 2'd1 : (e < 35) ? 2'd2 : 2'd1);
      if (e <= 10) begin
        chk("post.pclk_pos", pclk_o, pc_pos(e));
        @(negedge fclk_w);
        #1;
        chk("post.pclk_neg", pclk_o, pc_neg(e));
      end
      in_valid = (e == 24);
      in_data  = (e == 24) ? 10'h0AB : 10'h000;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
